// File: rtl/dispatch_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dispatch_unit_pkg
// Brief    : Shared widths, reserved tag and operation encodings for dispatch
// Revision : 1.0 - initial release
// ============================================================================
package dispatch_unit_pkg;

  localparam int unsigned c_DATA_W = 32;
  localparam int unsigned c_ADDR_W = 32;
  localparam int unsigned c_ROB_W  = 4;
  localparam int unsigned c_OP_W   = 6;

  // ROB tag 0 is never allocated; it marks an operand with no producer.
  localparam logic [c_ROB_W-1:0] c_TAG_NONE = '0;

  typedef enum logic [c_OP_W-1:0] {
    OP_NOP  = 6'd0,
    OP_ADD  = 6'd1,
    OP_SUB  = 6'd2,
    OP_ADDI = 6'd3,
    OP_LW   = 6'd4,
    OP_SW   = 6'd5
  } op_e;

endpackage : dispatch_unit_pkg
`default_nettype wire

// File: rtl/dispatch_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : dispatch_unit_if
// Brief    : Decoder, regfile, ROB, CDB and issue-side signals of the dispatcher
// Revision : 1.0 - initial release
// ============================================================================
interface dispatch_unit_if
  import dispatch_unit_pkg::*;
#(
  parameter int unsigned DATA_W = c_DATA_W,
  parameter int unsigned ADDR_W = c_ADDR_W,
  parameter int unsigned ROB_W  = c_ROB_W,
  parameter int unsigned OP_W   = c_OP_W
);
  // control
  logic              rdy_in;
  logic              clear_in;
  // decoder side
  logic              inst_valid_in;
  logic              inst_ready_out;
  logic [OP_W-1:0]   op_in;
  logic              is_ls_in;
  logic [4:0]        rd_in;
  logic [4:0]        rs1_in;
  logic [4:0]        rs2_in;
  logic [DATA_W-1:0] imm_in;
  logic [ADDR_W-1:0] pos_in;
  // register file
  logic [ROB_W-1:0]  rf_q1_in;
  logic [ROB_W-1:0]  rf_q2_in;
  logic [DATA_W-1:0] rf_v1_in;
  logic [DATA_W-1:0] rf_v2_in;
  logic              rename_en_out;
  logic [4:0]        rename_rd_out;
  logic [ROB_W-1:0]  rename_tag_out;
  // reorder buffer
  logic              rob_full_in;
  logic [ROB_W-1:0]  rob_free_tag_in;
  logic              rob_alloc_out;
  logic [ROB_W-1:0]  rob_q1_out;
  logic [ROB_W-1:0]  rob_q2_out;
  logic              rob_rdy1_in;
  logic              rob_rdy2_in;
  logic [DATA_W-1:0] rob_val1_in;
  logic [DATA_W-1:0] rob_val2_in;
  // common data bus
  logic              cdb_alu_en_in;
  logic [ROB_W-1:0]  cdb_alu_tag_in;
  logic [DATA_W-1:0] cdb_alu_val_in;
  logic              cdb_lsb_en_in;
  logic [ROB_W-1:0]  cdb_lsb_tag_in;
  logic [DATA_W-1:0] cdb_lsb_val_in;
  // issue side
  logic              rs_full_in;
  logic              lsb_full_in;
  logic              rs_en_out;
  logic              lsb_en_out;
  logic [OP_W-1:0]   op_out;
  logic [DATA_W-1:0] v1_out;
  logic [DATA_W-1:0] v2_out;
  logic [DATA_W-1:0] imm_out;
  logic [ROB_W-1:0]  q1_out;
  logic [ROB_W-1:0]  q2_out;
  logic [ROB_W-1:0]  rob_id_out;
  logic [ADDR_W-1:0] pos_out;

  modport master (
    input  rdy_in, clear_in, inst_valid_in, op_in, is_ls_in, rd_in, rs1_in, rs2_in,
           imm_in, pos_in, rf_q1_in, rf_q2_in, rf_v1_in, rf_v2_in, rob_full_in,
           rob_free_tag_in, rob_rdy1_in, rob_rdy2_in, rob_val1_in, rob_val2_in,
           cdb_alu_en_in, cdb_alu_tag_in, cdb_alu_val_in, cdb_lsb_en_in,
           cdb_lsb_tag_in, cdb_lsb_val_in, rs_full_in, lsb_full_in,
    output inst_ready_out, rename_en_out, rename_rd_out, rename_tag_out, rob_alloc_out,
           rob_q1_out, rob_q2_out, rs_en_out, lsb_en_out, op_out, v1_out, v2_out,
           imm_out, q1_out, q2_out, rob_id_out, pos_out
  );

  modport slave (
    output rdy_in, clear_in, inst_valid_in, op_in, is_ls_in, rd_in, rs1_in, rs2_in,
           imm_in, pos_in, rf_q1_in, rf_q2_in, rf_v1_in, rf_v2_in, rob_full_in,
           rob_free_tag_in, rob_rdy1_in, rob_rdy2_in, rob_val1_in, rob_val2_in,
           cdb_alu_en_in, cdb_alu_tag_in, cdb_alu_val_in, cdb_lsb_en_in,
           cdb_lsb_tag_in, cdb_lsb_val_in, rs_full_in, lsb_full_in,
    input  inst_ready_out, rename_en_out, rename_rd_out, rename_tag_out, rob_alloc_out,
           rob_q1_out, rob_q2_out, rs_en_out, lsb_en_out, op_out, v1_out, v2_out,
           imm_out, q1_out, q2_out, rob_id_out, pos_out
  );

endinterface : dispatch_unit_if
`default_nettype wire

// File: rtl/dispatch_unit_operand_resolver.sv
`default_nettype none
// ============================================================================
// Module   : dispatch_unit_operand_resolver
// Brief    : Resolves one source operand to a value or a producer tag
// Revision : 1.0 - initial release
// ============================================================================
module dispatch_unit_operand_resolver
  import dispatch_unit_pkg::*;
#(
  parameter int unsigned DATA_W = c_DATA_W,
  parameter int unsigned ROB_W  = c_ROB_W
) (
  input  wire logic [4:0]        i_rs,
  input  wire logic [ROB_W-1:0]  i_rf_q,
  input  wire logic [DATA_W-1:0] i_rf_v,
  input  wire logic              i_trk_valid,
  input  wire logic [4:0]        i_trk_rd,
  input  wire logic [ROB_W-1:0]  i_trk_tag,
  input  wire logic              i_alu_en,
  input  wire logic [ROB_W-1:0]  i_alu_tag,
  input  wire logic [DATA_W-1:0] i_alu_val,
  input  wire logic              i_lsb_en,
  input  wire logic [ROB_W-1:0]  i_lsb_tag,
  input  wire logic [DATA_W-1:0] i_lsb_val,
  input  wire logic              i_rob_rdy,
  input  wire logic [DATA_W-1:0] i_rob_val,
  output logic      [DATA_W-1:0] o_v,
  output logic      [ROB_W-1:0]  o_q
);

  // Priority chain; the tracker wins over the regfile because the previous
  // instruction's rename has not yet reached the regfile read port.
  always_comb begin
    o_v = '0;
    o_q = c_TAG_NONE;
    if (i_rs == 5'd0) begin
      o_v = '0;
      o_q = c_TAG_NONE;
    end else if (i_trk_valid && (i_trk_rd == i_rs)) begin
      o_q = i_trk_tag;
    end else if (i_rf_q == c_TAG_NONE) begin
      o_v = i_rf_v;
    end else if (i_alu_en && (i_alu_tag == i_rf_q)) begin
      o_v = i_alu_val;
    end else if (i_lsb_en && (i_lsb_tag == i_rf_q)) begin
      o_v = i_lsb_val;
    end else if (i_rob_rdy) begin
      o_v = i_rob_val;
    end else begin
      o_q = i_rf_q;
    end
  end

endmodule : dispatch_unit_operand_resolver
`default_nettype wire

// File: rtl/dispatch_unit.sv
`default_nettype none
// ============================================================================
// Module   : dispatch_unit
// Brief    : Accepts one decoded instruction per cycle, renames rd, allocates
//            a ROB entry and issues a registered packet to the RS or LSB
// Revision : 1.0 - initial release
// ============================================================================
module dispatch_unit
  import dispatch_unit_pkg::*;
#(
  parameter int unsigned DATA_W = c_DATA_W,
  parameter int unsigned ADDR_W = c_ADDR_W,
  parameter int unsigned ROB_W  = c_ROB_W,
  parameter int unsigned OP_W   = c_OP_W
) (
  input  wire logic        clk_in,
  input  wire logic        rst_in,
  dispatch_unit_if.master  bus
);

  logic              w_route_free;
  logic              w_ready;
  logic              w_accept;
  logic [DATA_W-1:0] w_v1;
  logic [DATA_W-1:0] w_v2;
  logic [ROB_W-1:0]  w_q1;
  logic [ROB_W-1:0]  w_q2;

  logic              r_rs_en;
  logic              r_lsb_en;
  logic [OP_W-1:0]   r_op;
  logic [DATA_W-1:0] r_v1;
  logic [DATA_W-1:0] r_v2;
  logic [DATA_W-1:0] r_imm;
  logic [ROB_W-1:0]  r_q1;
  logic [ROB_W-1:0]  r_q2;
  logic [ROB_W-1:0]  r_rob_id;
  logic [ADDR_W-1:0] r_pos;
  logic              r_trk_valid;
  logic [4:0]        r_trk_rd;
  logic [ROB_W-1:0]  r_trk_tag;

  // Downstream full flags already reserve room for the packet in flight.
  assign w_route_free = bus.is_ls_in ? !bus.lsb_full_in : !bus.rs_full_in;
  assign w_ready      = bus.rdy_in && !bus.clear_in && !bus.rob_full_in && w_route_free;
  assign w_accept     = bus.inst_valid_in && w_ready;

  assign bus.inst_ready_out = w_ready;
  assign bus.rob_alloc_out  = w_accept;
  assign bus.rename_en_out  = w_accept && (bus.rd_in != 5'd0);
  assign bus.rename_rd_out  = bus.rd_in;
  assign bus.rename_tag_out = bus.rob_free_tag_in;
  assign bus.rob_q1_out     = bus.rf_q1_in;
  assign bus.rob_q2_out     = bus.rf_q2_in;

  dispatch_unit_operand_resolver #(.DATA_W(DATA_W), .ROB_W(ROB_W)) u_res1 (
    .i_rs(bus.rs1_in), .i_rf_q(bus.rf_q1_in), .i_rf_v(bus.rf_v1_in),
    .i_trk_valid(r_trk_valid), .i_trk_rd(r_trk_rd), .i_trk_tag(r_trk_tag),
    .i_alu_en(bus.cdb_alu_en_in), .i_alu_tag(bus.cdb_alu_tag_in), .i_alu_val(bus.cdb_alu_val_in),
    .i_lsb_en(bus.cdb_lsb_en_in), .i_lsb_tag(bus.cdb_lsb_tag_in), .i_lsb_val(bus.cdb_lsb_val_in),
    .i_rob_rdy(bus.rob_rdy1_in), .i_rob_val(bus.rob_val1_in),
    .o_v(w_v1), .o_q(w_q1)
  );

  dispatch_unit_operand_resolver #(.DATA_W(DATA_W), .ROB_W(ROB_W)) u_res2 (
    .i_rs(bus.rs2_in), .i_rf_q(bus.rf_q2_in), .i_rf_v(bus.rf_v2_in),
    .i_trk_valid(r_trk_valid), .i_trk_rd(r_trk_rd), .i_trk_tag(r_trk_tag),
    .i_alu_en(bus.cdb_alu_en_in), .i_alu_tag(bus.cdb_alu_tag_in), .i_alu_val(bus.cdb_alu_val_in),
    .i_lsb_en(bus.cdb_lsb_en_in), .i_lsb_tag(bus.cdb_lsb_tag_in), .i_lsb_val(bus.cdb_lsb_val_in),
    .i_rob_rdy(bus.rob_rdy2_in), .i_rob_val(bus.rob_val2_in),
    .o_v(w_v2), .o_q(w_q2)
  );

  // Issue register and last-issue tracker; a flush wins over the freeze,
  // and a freeze holds the strobes so downstream consumes the packet once.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_rs_en     <= 1'b0;
      r_lsb_en    <= 1'b0;
      r_op        <= '0;
      r_v1        <= '0;
      r_v2        <= '0;
      r_imm       <= '0;
      r_q1        <= '0;
      r_q2        <= '0;
      r_rob_id    <= '0;
      r_pos       <= '0;
      r_trk_valid <= 1'b0;
      r_trk_rd    <= '0;
      r_trk_tag   <= '0;
    end else if (bus.clear_in) begin
      r_rs_en     <= 1'b0;
      r_lsb_en    <= 1'b0;
      r_trk_valid <= 1'b0;
    end else if (bus.rdy_in) begin
      if (w_accept) begin
        r_rs_en     <= !bus.is_ls_in;
        r_lsb_en    <= bus.is_ls_in;
        r_op        <= bus.op_in;
        r_v1        <= w_v1;
        r_v2        <= w_v2;
        r_imm       <= bus.imm_in;
        r_q1        <= w_q1;
        r_q2        <= w_q2;
        r_rob_id    <= bus.rob_free_tag_in;
        r_pos       <= bus.pos_in;
        r_trk_valid <= (bus.rd_in != 5'd0);
        r_trk_rd    <= bus.rd_in;
        r_trk_tag   <= bus.rob_free_tag_in;
      end else begin
        r_rs_en     <= 1'b0;
        r_lsb_en    <= 1'b0;
        r_trk_valid <= 1'b0;
      end
    end
  end

  assign bus.rs_en_out  = r_rs_en;
  assign bus.lsb_en_out = r_lsb_en;
  assign bus.op_out     = r_op;
  assign bus.v1_out     = r_v1;
  assign bus.v2_out     = r_v2;
  assign bus.imm_out    = r_imm;
  assign bus.q1_out     = r_q1;
  assign bus.q2_out     = r_q2;
  assign bus.rob_id_out = r_rob_id;
  assign bus.pos_out    = r_pos;

endmodule : dispatch_unit
`default_nettype wire

// File: tb/tb_dispatch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_dispatch_unit
// Brief    : Directed scoreboard bench for dispatch_unit
// Revision : 1.0 - initial release
// ============================================================================
module tb_dispatch_unit;
  import dispatch_unit_pkg::*;

  typedef struct {
    logic        is_ls;
    logic [5:0]  op;
    logic [31:0] v1;
    logic [31:0] v2;
    logic [31:0] imm;
    logic [3:0]  q1;
    logic [3:0]  q2;
    logic [3:0]  rob_id;
    logic [31:0] pos;
  } pkt_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;
  pkt_t exp_q[$];

  dispatch_unit_if bus ();

  dispatch_unit u_dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: a strobe is consumed at an edge where rdy_in is high.
  always @(negedge clk) begin
    if (rst && bus.rdy_in && (bus.rs_en_out || bus.lsb_en_out)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_strobe", {30'd0, bus.lsb_en_out, bus.rs_en_out}, 32'd0);
      end else begin
        pkt_t e;
        e = exp_q.pop_front();
        check("rs_en",  {31'd0, bus.rs_en_out},  {31'd0, !e.is_ls});
        check("lsb_en", {31'd0, bus.lsb_en_out}, {31'd0, e.is_ls});
        check("op",     {26'd0, bus.op_out},     {26'd0, e.op});
        check("v1",     bus.v1_out,  e.v1);
        check("v2",     bus.v2_out,  e.v2);
        check("imm",    bus.imm_out, e.imm);
        check("q1",     {28'd0, bus.q1_out},     {28'd0, e.q1});
        check("q2",     {28'd0, bus.q2_out},     {28'd0, e.q2});
        check("rob_id", {28'd0, bus.rob_id_out}, {28'd0, e.rob_id});
        check("pos",    bus.pos_out, e.pos);
      end
    end
  end

  task automatic idle();
    bus.rdy_in = 1'b1;          bus.clear_in = 1'b0;
    bus.inst_valid_in = 1'b0;   bus.op_in = '0;          bus.is_ls_in = 1'b0;
    bus.rd_in = '0;             bus.rs1_in = '0;         bus.rs2_in = '0;
    bus.imm_in = '0;            bus.pos_in = '0;
    bus.rf_q1_in = '0;          bus.rf_q2_in = '0;       bus.rf_v1_in = '0;   bus.rf_v2_in = '0;
    bus.rob_full_in = 1'b0;     bus.rob_free_tag_in = '0;
    bus.rob_rdy1_in = 1'b0;     bus.rob_rdy2_in = 1'b0;  bus.rob_val1_in = '0; bus.rob_val2_in = '0;
    bus.cdb_alu_en_in = 1'b0;   bus.cdb_alu_tag_in = '0; bus.cdb_alu_val_in = '0;
    bus.cdb_lsb_en_in = 1'b0;   bus.cdb_lsb_tag_in = '0; bus.cdb_lsb_val_in = '0;
    bus.rs_full_in = 1'b0;      bus.lsb_full_in = 1'b0;
  endtask

  task automatic inst(input logic [5:0] op, input logic ls, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm,
                      input logic [31:0] pos, input logic [3:0] tag);
    idle();
    bus.inst_valid_in = 1'b1; bus.op_in = op; bus.is_ls_in = ls;
    bus.rd_in = rd; bus.rs1_in = rs1; bus.rs2_in = rs2;
    bus.imm_in = imm; bus.pos_in = pos; bus.rob_free_tag_in = tag;
  endtask

  task automatic expect_pkt(input logic ls, input logic [5:0] op, input logic [31:0] v1,
                            input logic [3:0] q1, input logic [31:0] v2, input logic [3:0] q2,
                            input logic [31:0] imm, input logic [3:0] rob_id, input logic [31:0] pos);
    pkt_t p;
    p.is_ls = ls; p.op = op; p.v1 = v1; p.q1 = q1; p.v2 = v2; p.q2 = q2;
    p.imm = imm; p.rob_id = rob_id; p.pos = pos;
    exp_q.push_back(p);
  endtask

  task automatic to_negedge(); @(negedge clk); endtask
  task automatic next_cycle(); @(posedge clk); #1; endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    idle();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    to_negedge();
    check("rst_rs_en",  {31'd0, bus.rs_en_out},  32'd0);
    check("rst_lsb_en", {31'd0, bus.lsb_en_out}, 32'd0);
    check("rst_v1",     bus.v1_out,  32'd0);
    check("rst_imm",    bus.imm_out, 32'd0);
    check("rst_rob_id", {28'd0, bus.rob_id_out}, 32'd0);
    check("rst_pos",    bus.pos_out, 32'd0);
    next_cycle();
    rst = 1'b1;

    // ADDI x1,x0,5 -> tag 3
    inst(OP_ADDI, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5, 32'h100, 4'd3);
    expect_pkt(1'b0, OP_ADDI, 32'd0, 4'd0, 32'd0, 4'd0, 32'd5, 4'd3, 32'h100);
    to_negedge();
    check("ready_addi",  {31'd0, bus.inst_ready_out}, 32'd1);
    check("alloc_addi",  {31'd0, bus.rob_alloc_out},  32'd1);
    check("rename_en",   {31'd0, bus.rename_en_out},  32'd1);
    check("rename_rd",   {27'd0, bus.rename_rd_out},  32'd1);
    check("rename_tag",  {28'd0, bus.rename_tag_out}, 32'd3);
    next_cycle();

    // ADD x2,x1,x1 while regfile still shows x1 as ready stale data
    inst(OP_ADD, 1'b0, 5'd2, 5'd1, 5'd1, 32'd0, 32'h104, 4'd4);
    bus.rf_v1_in = 32'h99; bus.rf_v2_in = 32'h99;
    expect_pkt(1'b0, OP_ADD, 32'd0, 4'd3, 32'd0, 4'd3, 32'd0, 4'd4, 32'h104);
    next_cycle();

    // ALU CDB bypass on rs1, ready regfile value on rs2
    inst(OP_ADD, 1'b0, 5'd8, 5'd6, 5'd7, 32'd0, 32'h108, 4'd6);
    bus.rf_q1_in = 4'd5; bus.rf_v1_in = 32'h77;
    bus.cdb_alu_en_in = 1'b1; bus.cdb_alu_tag_in = 4'd5; bus.cdb_alu_val_in = 32'hDEAD;
    bus.rf_v2_in = 32'h11;
    expect_pkt(1'b0, OP_ADD, 32'hDEAD, 4'd0, 32'h11, 4'd0, 32'd0, 4'd6, 32'h108);
    next_cycle();

    // ROB-ready on rs1, unresolved producer on rs2 (LSB CDB tag mismatch)
    inst(OP_SUB, 1'b0, 5'd10, 5'd6, 5'd9, 32'd0, 32'h10C, 4'd7);
    bus.rf_q1_in = 4'd5; bus.rob_rdy1_in = 1'b1; bus.rob_val1_in = 32'd7;
    bus.rf_q2_in = 4'd4; bus.rob_val2_in = 32'h123;
    bus.cdb_lsb_en_in = 1'b1; bus.cdb_lsb_tag_in = 4'd2; bus.cdb_lsb_val_in = 32'h222;
    expect_pkt(1'b0, OP_SUB, 32'd7, 4'd0, 32'd0, 4'd4, 32'd0, 4'd7, 32'h10C);
    to_negedge();
    check("rob_q1", {28'd0, bus.rob_q1_out}, 32'd5);
    check("rob_q2", {28'd0, bus.rob_q2_out}, 32'd4);
    next_cycle();

    // LSB CDB bypass on rs2
    inst(OP_ADD, 1'b0, 5'd12, 5'd0, 5'd9, 32'd0, 32'h110, 4'd8);
    bus.rf_q2_in = 4'd9;
    bus.cdb_lsb_en_in = 1'b1; bus.cdb_lsb_tag_in = 4'd9; bus.cdb_lsb_val_in = 32'hBEEF;
    expect_pkt(1'b0, OP_ADD, 32'd0, 4'd0, 32'hBEEF, 4'd0, 32'd0, 4'd8, 32'h110);
    next_cycle();

    // Load blocked by a full LSB
    inst(OP_LW, 1'b1, 5'd3, 5'd3, 5'd0, 32'd4, 32'h114, 4'd9);
    bus.rf_v1_in = 32'h40; bus.lsb_full_in = 1'b1;
    to_negedge();
    check("ready_lsb_full",  {31'd0, bus.inst_ready_out}, 32'd0);
    check("alloc_lsb_full",  {31'd0, bus.rob_alloc_out},  32'd0);
    check("rename_lsb_full", {31'd0, bus.rename_en_out},  32'd0);
    next_cycle();

    // Same load accepted; rs1 == rd resolves pre-rename
    bus.lsb_full_in = 1'b0;
    expect_pkt(1'b1, OP_LW, 32'h40, 4'd0, 32'd0, 4'd0, 32'd4, 4'd9, 32'h114);
    to_negedge();
    check("ready_load", {31'd0, bus.inst_ready_out}, 32'd1);
    next_cycle();

    // ROB full blocks both routes
    inst(OP_ADD, 1'b0, 5'd4, 5'd1, 5'd2, 32'd0, 32'h200, 4'd10);
    bus.rob_full_in = 1'b1;
    to_negedge();
    check("ready_robfull_rs", {31'd0, bus.inst_ready_out}, 32'd0);
    next_cycle();
    inst(OP_SW, 1'b1, 5'd0, 5'd1, 5'd2, 32'd0, 32'h204, 4'd10);
    bus.rob_full_in = 1'b1;
    to_negedge();
    check("ready_robfull_ls", {31'd0, bus.inst_ready_out}, 32'd0);
    check("alloc_robfull_ls", {31'd0, bus.rob_alloc_out},  32'd0);
    next_cycle();

    // Accept, then flush with a valid instruction present
    inst(OP_ADD, 1'b0, 5'd4, 5'd5, 5'd6, 32'd0, 32'h118, 4'd10);
    bus.rf_v1_in = 32'd1; bus.rf_v2_in = 32'd2;
    expect_pkt(1'b0, OP_ADD, 32'd1, 4'd0, 32'd2, 4'd0, 32'd0, 4'd10, 32'h118);
    next_cycle();
    inst(OP_ADD, 1'b0, 5'd5, 5'd1, 5'd2, 32'd0, 32'h11C, 4'd11);
    bus.clear_in = 1'b1;
    to_negedge();
    check("ready_clear", {31'd0, bus.inst_ready_out}, 32'd0);
    check("alloc_clear", {31'd0, bus.rob_alloc_out},  32'd0);
    next_cycle();
    idle();
    to_negedge();
    check("en_after_clear", {30'd0, bus.lsb_en_out, bus.rs_en_out}, 32'd0);
    next_cycle();

    // Freeze: strobe held while rdy_in is low, consumed once afterwards
    inst(OP_ADDI, 1'b0, 5'd6, 5'd4, 5'd0, 32'd1, 32'h11C, 4'd11);
    bus.rf_v1_in = 32'h44;
    expect_pkt(1'b0, OP_ADDI, 32'h44, 4'd0, 32'd0, 4'd0, 32'd1, 4'd11, 32'h11C);
    next_cycle();
    for (int i = 0; i < 3; i++) begin
      idle();
      bus.rdy_in = 1'b0;
      to_negedge();
      check("rs_en_frozen", {31'd0, bus.rs_en_out},      32'd1);
      check("ready_frozen", {31'd0, bus.inst_ready_out}, 32'd0);
      next_cycle();
    end
    idle();
    next_cycle();
    to_negedge();
    check("rs_en_after_freeze", {31'd0, bus.rs_en_out}, 32'd0);
    next_cycle();

    // rd = x0: no rename, tracker left invalid
    inst(OP_ADDI, 1'b0, 5'd0, 5'd6, 5'd0, 32'd9, 32'h120, 4'd12);
    bus.rf_v1_in = 32'd3;
    expect_pkt(1'b0, OP_ADDI, 32'd3, 4'd0, 32'd0, 4'd0, 32'd9, 4'd12, 32'h120);
    to_negedge();
    check("rename_x0", {31'd0, bus.rename_en_out}, 32'd0);
    check("alloc_x0",  {31'd0, bus.rob_alloc_out}, 32'd1);
    next_cycle();

    // rs1 = x0 ignores whatever the regfile reports
    inst(OP_ADD, 1'b0, 5'd7, 5'd0, 5'd0, 32'd0, 32'h124, 4'd13);
    bus.rf_q1_in = 4'd5; bus.rf_v1_in = 32'h55;
    expect_pkt(1'b0, OP_ADD, 32'd0, 4'd0, 32'd0, 4'd0, 32'd0, 4'd13, 32'h124);
    next_cycle();

    idle();
    repeat (4) next_cycle();
    check("scoreboard_empty", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #20000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule : tb_dispatch_unit
`default_nettype wire
